// File: rtl/spi_slave_if.sv
// Serial pins and parallel TX/RX side of the SPI responder, bundled into one interface.
// The slave modport is the responder's view and the master modport is the view of whatever drives it.
interface spi_slave_if #(
  parameter int COUNT_W = 16
);
  logic               sck;
  logic               cs_n;
  logic               mosi;
  logic               miso;
  logic               miso_oe;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic [COUNT_W-1:0] byte_count;
  logic               frame_done;
  logic               tx_underrun;
  logic               busy;

  modport slave (
    input  sck, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid,
    output byte_count, frame_done, tx_underrun, busy
  );

  modport master (
    output sck, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid,
    input  byte_count, frame_done, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, LSB-first, 8-bit frames.
// sck, cs_n and mosi are oversampled on sysclk. TX goes through a one-deep holding register.
module spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16
) (
  input logic       sysclk,
  input logic       rst,
  spi_slave_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_n_d;
  logic                   sck_s;
  logic                   cs_n_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_fall;

  logic [7:0]         hold_data;
  logic               hold_full;
  logic [7:0]         load_val;
  logic [6:0]         tx_shift;     // bits still to be sent after the one on miso
  logic [6:0]         rx_shift;     // bits collected so far, newest at the top
  logic [7:0]         rx_next;
  logic [2:0]         bit_cnt;
  logic               reload_pending;
  logic               miso_r;
  logic               miso_oe_r;
  logic [7:0]         rx_data_r;
  logic               rx_valid_r;
  logic [COUNT_W-1:0] byte_cnt_r;
  logic               frame_done_r;
  logic               underrun_r;
  logic               busy_r;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_n_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_n_s & cs_n_d;

  // An empty holding register sends zeros. The caller flags that as an underrun.
  assign load_val = hold_full ? hold_data : 8'h00;
  assign rx_next  = {mosi_s, rx_shift};

  // Sync sck and cs_n, plus one delay stage for edge detection.
  // cs_n resets low, so WAIT_HIGH only exits once cs_n has really been seen high.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      sck_sync <= '0;
      cs_sync  <= '0;
      sck_d    <= 1'b0;
      cs_n_d   <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      sck_d    <= sck_s;
      cs_n_d   <= cs_n_s;
    end
  end

  // mosi sync chain. It is data only and needs no reset.
  always_ff @(posedge sysclk) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
  end

  // Frame FSM, shift registers and TX holding-register handshake.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state          <= WAIT_HIGH;
      hold_full      <= 1'b0;
      bit_cnt        <= 3'd0;
      reload_pending <= 1'b0;
      miso_r         <= 1'b0;
      miso_oe_r      <= 1'b0;
      rx_data_r      <= 8'h00;
      rx_valid_r     <= 1'b0;
      byte_cnt_r     <= '0;
      frame_done_r   <= 1'b0;
      underrun_r     <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      rx_valid_r   <= 1'b0;
      frame_done_r <= 1'b0;

      // A capture only happens when the register is empty, so it never races a reload that consumes it.
      if (bus.tx_valid && !hold_full) begin
        hold_data <= bus.tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        WAIT_HIGH: begin
          if (cs_n_s) state <= IDLE;
        end

        IDLE: begin
          if (cs_fall) begin
            state          <= ACTIVE;
            busy_r         <= 1'b1;
            bit_cnt        <= 3'd0;
            byte_cnt_r     <= '0;
            reload_pending <= 1'b0;
            tx_shift       <= load_val[7:1];
            miso_r         <= load_val[0];
            miso_oe_r      <= 1'b1;
            underrun_r     <= ~hold_full;
            if (hold_full) hold_full <= 1'b0;
          end
        end

        ACTIVE: begin
          // cs_n rising wins over a coincident sck edge and discards any partial byte.
          if (cs_n_s) begin
            state          <= IDLE;
            busy_r         <= 1'b0;
            frame_done_r   <= 1'b1;
            miso_oe_r      <= 1'b0;
            miso_r         <= 1'b0;
            reload_pending <= 1'b0;
          end else if (sck_rise) begin
            rx_shift <= rx_next[7:1];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_r      <= rx_next;
              rx_valid_r     <= 1'b1;
              byte_cnt_r     <= byte_cnt_r + 1'b1;
              reload_pending <= 1'b1;
            end
          end else if (sck_fall) begin
            if (reload_pending) begin
              tx_shift       <= load_val[7:1];
              miso_r         <= load_val[0];
              reload_pending <= 1'b0;
              if (hold_full) hold_full <= 1'b0;
              else           underrun_r <= 1'b1;
            end else begin
              tx_shift <= {1'b0, tx_shift[6:1]};
              miso_r   <= tx_shift[0];
            end
          end
        end

        default: state <= WAIT_HIGH;
      endcase
    end
  end

  assign bus.miso        = miso_r;
  assign bus.miso_oe     = miso_oe_r;
  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.byte_count  = byte_cnt_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.tx_underrun = underrun_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave. It runs a mode-0 LSB-first master at sysclk/8.
// A transaction-level model of the TX byte stream and the RX byte stream sits beside the master.
module tb_spi_slave;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;

  spi_slave_if #(.COUNT_W(16)) sif();

  spi_slave #(.SYNC_STAGES(2), .COUNT_W(16)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (sif.slave)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  int n_rxv  = 0;
  int n_fd   = 0;
  int frame_rx = 0;

  logic [7:0] exp_rx[$];     // bytes the slave must report on rx_valid, in order
  logic [7:0] tx_fifo[$];    // bytes written to the slave and not yet sent
  logic [7:0] exp_tx[4];     // bytes the master must see on miso in this frame
  logic       exp_underrun;
  logic [7:0] mb[4];         // master transmit bytes
  logic [7:0] fd[4];         // bytes fed through the handshake during the frame
  logic [7:0] rcv[4];        // bytes the master collected from miso

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Each new byte takes the oldest written byte, or zeros if none is available.
  task automatic model_next_byte(input int b);
    if (tx_fifo.size() > 0) exp_tx[b] = tx_fifo.pop_front();
    else begin
      exp_tx[b]    = 8'h00;
      exp_underrun = 1'b1;
    end
  endtask

  task automatic preload(input logic [7:0] d);
    chk("tx_ready_before_write", sif.tx_ready, 1);
    sif.tx_valid = 1'b1;
    sif.tx_data  = d;
    tick(1);
    sif.tx_valid = 1'b0;
    tx_fifo.push_back(d);
    chk("tx_ready_after_write", sif.tx_ready, 0);
  endtask

  // Runs nbits rising sck edges. The last falling edge coincides with cs_n rising.
  // Bytes fd[0..nfeed-1] are written during bytes 0..nfeed-1.
  task automatic spi_frame(input int nbits, input int nfeed);
    int b;
    int k;
    int fd0;
    fd0 = n_fd;
    exp_underrun = 1'b0;
    model_next_byte(0);
    for (int j = 0; j < 4; j++) rcv[j] = 8'h00;
    sif.cs_n = 1'b0;
    sif.mosi = mb[0][0];
    tick(4);
    chk("busy_in_frame", sif.busy, 1);
    chk("miso_oe_in_frame", sif.miso_oe, 1);
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      b = i / 8;
      k = i % 8;
      sif.mosi = mb[b][k];
      if (i > 0) begin
        if (k == 3 && b < nfeed) begin
          chk("tx_ready_mid_frame", sif.tx_ready, 1);
          sif.tx_valid = 1'b1;
          sif.tx_data  = fd[b];
          tx_fifo.push_back(fd[b]);
          tick(1);
          sif.tx_valid = 1'b0;
          tick(3);
        end else tick(4);
      end
      rcv[b][k] = sif.miso;
      if (k == 7) exp_rx.push_back(mb[b]);
      sif.sck = 1'b1;
      tick(4);
      sif.sck = 1'b0;
      if (i == nbits - 1) sif.cs_n = 1'b1;
      else if (k == 7) model_next_byte(b + 1);
    end
    tick(10);
    chk("frame_done_count", n_fd - fd0, 1);
    chk("busy_after_frame", sif.busy, 0);
    chk("miso_oe_after_frame", sif.miso_oe, 0);
    chk("miso_after_frame", sif.miso, 0);
    chk("byte_count_end", sif.byte_count, nbits / 8);
    chk("tx_underrun_end", sif.tx_underrun, exp_underrun);
    chk("rx_queue_drained", exp_rx.size(), 0);
    for (int j = 0; j < nbits / 8; j++) chk("miso_byte", rcv[j], exp_tx[j]);
  endtask

  // Per-cycle checks on strobes and on the pad enable.
  initial begin
    logic cs_prev;
    logic rxv_prev;
    logic fd_prev;
    cs_prev  = 1'b1;
    rxv_prev = 1'b0;
    fd_prev  = 1'b0;
    forever begin
      @(negedge sysclk);
      if (cs_prev && !sif.cs_n) frame_rx = 0;
      cs_prev = sif.cs_n;
      chk("miso_oe_vs_busy", sif.miso_oe, sif.busy);
      if (sif.rx_valid) begin
        chk("rx_valid_one_cycle", rxv_prev, 0);
        n_rxv++;
        frame_rx++;
        chk("rx_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) chk("rx_data", sif.rx_data, exp_rx.pop_front());
        chk("byte_count_at_rx", sif.byte_count, frame_rx);
      end
      if (sif.frame_done) begin
        chk("frame_done_one_cycle", fd_prev, 0);
        n_fd++;
      end
      rxv_prev = sif.rx_valid;
      fd_prev  = sif.frame_done;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rx0;
    int fd0;
    sif.cs_n     = 1'b1;
    sif.sck      = 1'b0;
    sif.mosi     = 1'b0;
    sif.tx_valid = 1'b0;
    sif.tx_data  = 8'h00;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("rst_miso", sif.miso, 0);
    chk("rst_miso_oe", sif.miso_oe, 0);
    chk("rst_tx_ready", sif.tx_ready, 1);
    chk("rst_rx_data", sif.rx_data, 0);
    chk("rst_rx_valid", sif.rx_valid, 0);
    chk("rst_byte_count", sif.byte_count, 0);
    chk("rst_frame_done", sif.frame_done, 0);
    chk("rst_tx_underrun", sif.tx_underrun, 0);
    chk("rst_busy", sif.busy, 0);
    tick(3);

    // Single byte: A5 out, 3C in.
    rx0 = n_rxv;
    preload(8'hA5);
    mb[0] = 8'h3C;
    spi_frame(8, 0);
    chk("t1_master_rx", rcv[0], 8'hA5);
    chk("t1_rx_data", sif.rx_data, 8'h3C);
    chk("t1_rx_strobes", n_rxv - rx0, 1);
    chk("t1_byte_count", sif.byte_count, 1);

    // Three bytes with TX refilled before each boundary.
    rx0 = n_rxv;
    preload(8'h10);
    mb[0] = 8'h01; mb[1] = 8'h02; mb[2] = 8'h03;
    fd[0] = 8'h20; fd[1] = 8'h30;
    spi_frame(24, 2);
    chk("t2_master_rx0", rcv[0], 8'h10);
    chk("t2_master_rx1", rcv[1], 8'h20);
    chk("t2_master_rx2", rcv[2], 8'h30);
    chk("t2_rx_data", sif.rx_data, 8'h03);
    chk("t2_rx_strobes", n_rxv - rx0, 3);
    chk("t2_byte_count", sif.byte_count, 3);
    chk("t2_underrun", sif.tx_underrun, 0);

    // Two bytes, only one written: the second byte is zeros and the underrun flag sticks.
    preload(8'h55);
    mb[0] = 8'hAA; mb[1] = 8'h0F;
    spi_frame(16, 0);
    chk("t3_master_rx0", rcv[0], 8'h55);
    chk("t3_master_rx1", rcv[1], 8'h00);
    chk("t3_underrun", sif.tx_underrun, 1);
    chk("t3_rx_data", sif.rx_data, 8'h0F);

    // One full byte plus 5 bits. The partial byte is dropped and the underrun flag is cleared.
    rx0 = n_rxv;
    preload(8'h66);
    mb[0] = 8'hC0; mb[1] = 8'h1F;
    fd[0] = 8'h99;
    spi_frame(13, 1);
    chk("t4_master_rx0", rcv[0], 8'h66);
    chk("t4_rx_strobes", n_rxv - rx0, 1);
    chk("t4_rx_data", sif.rx_data, 8'hC0);
    chk("t4_byte_count", sif.byte_count, 1);
    chk("t4_underrun_cleared", sif.tx_underrun, 0);
    tick(4);

    // Reset mid-byte with cs_n low: the slave must ignore the rest of that frame.
    preload(8'h77);
    sif.cs_n = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      sif.mosi = 1'b1;
      sif.sck  = 1'b1;
      tick(4);
      sif.sck  = 1'b0;
      tick(4);
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tx_fifo.delete();
    fd0 = n_fd;
    rx0 = n_rxv;
    for (int i = 0; i < 5; i++) begin
      sif.sck = 1'b1;
      tick(4);
      chk("t5_busy_after_rst", sif.busy, 0);
      chk("t5_miso_oe_after_rst", sif.miso_oe, 0);
      sif.sck = 1'b0;
      tick(4);
    end
    chk("t5_tx_ready", sif.tx_ready, 1);
    sif.cs_n = 1'b1;
    tick(6);
    chk("t5_no_frame_done", n_fd - fd0, 0);
    chk("t5_no_rx", n_rxv - rx0, 0);
    preload(8'h5A);
    mb[0] = 8'hC3;
    spi_frame(8, 0);
    chk("t5_master_rx", rcv[0], 8'h5A);
    chk("t5_rx_data", sif.rx_data, 8'hC3);
    chk("t5_rx_strobes", n_rxv - rx0, 1);

    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
